// File: rtl/block_ram_controller_if.sv
// Request/response bus between a core (master) and block_ram_controller (slave).
`default_nettype none

interface block_ram_controller_if #(
  parameter int WIDTH = 32
) ();
  localparam int B = WIDTH / 8;

  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [31:0]      req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [B-1:0]     req_wstrb;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

`default_nettype wire

// File: rtl/block_ram_controller.sv
// Byte-addressed request front end for a word-wide block RAM without byte enables;
// partial writes are done as read-modify-write. One request outstanding at a time.
`default_nettype none

module block_ram_controller #(
  parameter  int SIZE  = 1024,
  parameter  int WIDTH = 32,
  localparam int B     = WIDTH / 8,
  localparam int AW    = $clog2(SIZE / B),
  localparam int OFS   = $clog2(B)
) (
  input  logic                 clk,
  input  logic                 reset,
  block_ram_controller_if.slave bus,
  output logic                 ram_write_en,
  output logic [AW-1:0]        ram_write_address,
  output logic [WIDTH-1:0]     ram_write_data,
  output logic [AW-1:0]        ram_read_address,
  input  logic [WIDTH-1:0]     ram_read_data
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPTURE = 3'd2,
    WRITE      = 3'd3,
    RESP       = 3'd4
  } state_t;

  state_t           state, state_next;
  logic             wr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [B-1:0]     wstrb_q;
  logic [WIDTH-1:0] rdata_q;
  logic             error_q;
  logic [WIDTH-1:0] merged;
  logic             accept;
  logic             range_err;
  logic             misalign;
  logic             req_err;
  logic             strb_full;
  logic             strb_zero;
  logic [AW-1:0]    index;

  assign accept    = bus.req_valid && (state == IDLE);
  assign range_err = bus.req_addr >= 32'(SIZE);
  assign req_err   = range_err || misalign;
  assign strb_full = &bus.req_wstrb;
  assign strb_zero = ~|bus.req_wstrb;
  assign index     = bus.req_addr[OFS+AW-1:OFS];

  generate
    if (OFS > 0) begin : g_align
      assign misalign = |bus.req_addr[OFS-1:0];
    end else begin : g_no_align
      assign misalign = 1'b0;
    end
  endgenerate

  for (genvar i = 0; i < B; i++) begin : g_merge
    assign merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : ram_read_data[8*i +: 8];
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;
  assign ram_write_en   = (state == WRITE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err || (bus.req_write && strb_zero)) state_next = RESP;
          else if (bus.req_write && strb_full)         state_next = WRITE;
          else                                         state_next = RD_ISSUE;
        end
      end
      RD_ISSUE:   state_next = RD_CAPTURE;
      RD_CAPTURE: state_next = wr_q ? WRITE : RESP;
      WRITE:      state_next = RESP;
      RESP:       if (bus.resp_ready) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q              <= 1'b0;
      wdata_q           <= '0;
      wstrb_q           <= '0;
      rdata_q           <= '0;
      error_q           <= 1'b0;
      ram_write_address <= '0;
      ram_write_data    <= '0;
      ram_read_address  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wr_q    <= bus.req_write;
            wdata_q <= bus.req_wdata;
            wstrb_q <= bus.req_wstrb;
            rdata_q <= '0;
            error_q <= req_err;
            if (!req_err && bus.req_write && strb_full) begin
              ram_write_address <= index;
              ram_write_data    <= bus.req_wdata;
            end else if (!req_err && !(bus.req_write && strb_zero)) begin
              ram_read_address  <= index;
            end
          end
        end
        RD_CAPTURE: begin
          // The read address still holds this request's word index.
          if (wr_q) begin
            ram_write_address <= ram_read_address;
            ram_write_data    <= merged;
          end else begin
            rdata_q <= ram_read_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
